aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
Iterative AES-128 key schedule. It accepts a 128-bit cipher key, generates the 11 round keys (rk0..rk10) at one per clock, and holds them in an internal key store. The store feeds the addroundkey stage through a combinational indexed read port. Each new round key is also streamed out as it is produced, for pipelined consumers.

Parameters:
- NUM_ROUNDS, 10, number of expanded rounds. Fixed for AES-128; any other value is out of scope.
- KEY_W, 128, key and round-key width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin expansion of key_in. Sampled only in IDLE.
- key_in  input  128  cipher key. Byte 0 is at [127:120]; word w0 is [127:96]; bytes are column-major.
- busy  output  1  high while expansion is in progress.
- done  output  1  one-cycle pulse when rk10 has been written.
- keys_valid  output  1  the full key store is valid.
- rk_idx  input  4  round index for the read port.
- round_key  output  128  combinational read of store[rk_idx]. Returns 0 when rk_idx > 10.
- rk_valid  output  1  one-cycle strobe; rk_data/rk_round are valid.
- rk_data  output  128  round key just written to the store.
- rk_round  output  4  index of rk_data.

Behaviour:
- Reset (rst_n=0 at an edge): FSM goes to IDLE; round counter = 0; all 11 store entries = 0; busy, done, keys_valid, rk_valid = 0; rk_data = 0; rk_round = 0.
- Reset during EXPAND aborts the expansion; keys_valid remains 0.
- FSM states:
  - IDLE: on start=1 at edge E0, store[0] <= key_in, keys_valid <= 0, counter <= 1, state <= EXPAND.
  - EXPAND: at edges E1..E10, store[r] <= f(store[r-1], Rcon[r]) and counter increments. At E10, state <= IDLE, done <= 1 for one cycle, keys_valid <= 1.
- Round function: temp = SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}; w0' = w0 ^ temp; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
- Output timing after E0:
  - busy is high from after E0 through the cycle ending at E10.
  - rk_valid pulses after each of E0..E10 (11 strobes total), with rk_round = 0..10.
- Latency: 10 cycles from start sampled to done/keys_valid high.
- start while busy is ignored; the in-progress expansion is unaffected.
- start and done in the same IDLE cycle: the new expansion begins and keys_valid drops to 0 at that edge.
- The store and keys_valid hold indefinitely in IDLE. key_in is sampled only at E0.
- The read port is purely combinational. Reading an index not yet written during EXPAND returns stale or zero data; consumers gate on keys_valid.
- No arithmetic beyond XOR. The counter is 4 bits and never exceeds 10.

Optional Feature:
- Macro: AES_KEY_ZEROIZE_EN.
- When defined:
  - Adds input port zeroize (1 bit).
  - zeroize=1 at an edge clears all store entries to 0, forces keys_valid, busy, done and rk_valid to 0, and returns the FSM to IDLE.
  - zeroize has priority over start. rst_n still has the highest priority.
- When undefined: the port is absent and the store changes only through reset or expansion.

Decomposition:
- Shared package aes_pkg:
  - Rcon table: 01,02,04,08,10,20,40,80,1b,36.
  - Constants AES_NUM_ROUNDS and AES_KEY_W.
  - typedef for a 128-bit state/key.
  - FSM state enum.
- Sub-module aes_sbox: combinational 8-bit forward S-box, instantiated 4x for SubWord. The SubBytes stage reuses it.

Test Plan:
- Reset, then start with key_in = 2b7e151628aed2a6abf7158809cf4f3c:
  - rk1 = a0fafe1788542cb123a339392a6c7605.
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done occurs exactly 10 cycles after start.
  - 11 rk_valid strobes with rk_round 0..10.
- Key all zeros:
  - rk1 = 62636363626363636263636362636363.
  - rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - rk_idx = 11..15 reads 0.
- Pulse start again at cycles 3 and 7 of an expansion: both are ignored; results are identical to a single start; done fires once.
- Assert rst_n=0 at cycle 5 of an expansion: at the next edge busy=0, keys_valid=0, and round_key reads 0 for rk_idx 0..10.
- Back-to-back runs: start with a new key in the cycle after done. keys_valid falls and rises again 10 cycles later with the new FIPS values.
- With AES_KEY_ZEROIZE_EN: zeroize after keys_valid clears all entries to 0. zeroize and start in the same cycle leaves the FSM in IDLE with no expansion started.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 constants, key type, key-schedule FSM states and Rcon lookup
package aes_pkg;
  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_KEY_W = 128;
  typedef logic [AES_KEY_W-1:0] aes_key_t;
  typedef enum logic {IDLE, EXPAND} aes_state_e;
  localparam logic [79:0] RCON = 80'h01_02_04_08_10_20_40_80_1b_36;
  function automatic logic [7:0] aes_rcon(logic [3:0] r);
    return (r >= 4'd1 && r <= 4'd10) ? RCON[8*(10-int'(r)) +: 8] : 8'h00;
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box (in_i byte -> out_o substituted byte)
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign out_o = SBOX[{~in_i, 3'b000} +: 8];
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule; start/key_in in, 11-entry store read via rk_idx/round_key, rk_* stream out, busy/done/keys_valid status; zeroize port when AES_KEY_ZEROIZE_EN is defined
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int KEY_W = AES_KEY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic             zeroize,
`endif
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic [3:0]       rk_idx,
  output logic [KEY_W-1:0] round_key,
  output logic             rk_valid,
  output logic [KEY_W-1:0] rk_data,
  output logic [3:0]       rk_round
);
  aes_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d, rk_round_q, rk_round_d, wr_idx;
  logic done_q, done_d, keys_valid_q, keys_valid_d, rk_valid_q, rk_valid_d;
  logic go, step, last, wr, zero;
  aes_key_t rk_data_q, rk_data_d, rk_d, nxt_key;
  aes_key_t store_q [NUM_ROUNDS+1];
  logic [31:0] rot_w, sub_w, w0, w1, w2, w3;
`ifdef AES_KEY_ZEROIZE_EN
  assign zero = zeroize;
`else
  assign zero = 1'b0;
`endif
  // rk_data_q always holds the previous round key while expanding, so it feeds the round function directly
  assign rot_w = {rk_data_q[23:0], rk_data_q[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.in_i(rot_w[8*i +: 8]), .out_o(sub_w[8*i +: 8]));
  end
  assign w0 = rk_data_q[127:96] ^ sub_w ^ {aes_rcon(cnt_q), 24'h0};
  assign w1 = rk_data_q[95:64] ^ w0;
  assign w2 = rk_data_q[63:32] ^ w1;
  assign w3 = rk_data_q[31:0] ^ w2;
  assign nxt_key = {w0, w1, w2, w3};
  assign go = state_q == IDLE && start;
  assign step = state_q == EXPAND;
  assign last = step && cnt_q == 4'(NUM_ROUNDS);
  assign wr = go || step;
  assign wr_idx = go ? 4'd0 : cnt_q;
  assign rk_d = go ? key_in : nxt_key;
  always_comb begin
    state_d = go ? EXPAND : last ? IDLE : state_q;
    cnt_d = go ? 4'd1 : last ? 4'd0 : step ? cnt_q + 4'd1 : cnt_q;
    done_d = last;
    keys_valid_d = go ? 1'b0 : last ? 1'b1 : keys_valid_q;
    rk_valid_d = wr;
    rk_data_d = wr ? rk_d : rk_data_q;
    rk_round_d = wr ? wr_idx : rk_round_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || zero) begin
      state_q <= IDLE;
      cnt_q <= '0;
      done_q <= 1'b0;
      keys_valid_q <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_data_q <= '0;
      rk_round_q <= '0;
      store_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      keys_valid_q <= keys_valid_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q <= rk_data_d;
      rk_round_q <= rk_round_d;
      if (wr) store_q[wr_idx] <= rk_d;
    end
  end
  assign busy = state_q == EXPAND;
  assign done = done_q;
  assign keys_valid = keys_valid_q;
  assign rk_valid = rk_valid_q;
  assign rk_data = rk_data_q;
  assign rk_round = rk_round_q;
  assign round_key = rk_idx <= 4'(NUM_ROUNDS) ? store_q[rk_idx] : '0;
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: directed and random checks of aes_key_expand against a GF(2^8)-derived key-schedule model
module tb_aes_key_expand;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0] rk_idx = '0;
  logic busy, done, keys_valid, rk_valid;
  logic [127:0] round_key, rk_data;
  logic [3:0] rk_round;
`ifdef AES_KEY_ZEROIZE_EN
  logic zeroize = 1'b0;
`endif
  int tests = 0, fails = 0;
  logic [7:0] sb [256];
  logic [127:0] exp_rk [11];
  always #25 clk = ~clk;
  aes_key_expand dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .busy(busy), .done(done), .keys_valid(keys_valid), .rk_idx(rk_idx),
    .round_key(round_key), .rk_valid(rk_valid), .rk_data(rk_data), .rk_round(rk_round)
  );
  task automatic check(string tag, logic [127:0] obs, logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map
  task automatic init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask
  function automatic void expand(logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction
  task automatic read_store(string tag, bit zeros);
    for (int i = 0; i < 16; i++) begin
      rk_idx = 4'(i);
      #1;
      if (i < 11 && !zeros) check($sformatf("%s_rd%0d", tag, i), round_key, exp_rk[i]);
      else check($sformatf("%s_rd%0d", tag, i), round_key, '0);
    end
  endtask
  // Ends in the cycle after E10 (done high), so a following call starts back-to-back
  task automatic run_key(string tag, logic [127:0] k, bit dup);
    expand(k);
    key_in = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key_in = ~k;
    check({tag, "_e0_valid"}, rk_valid, 1);
    check({tag, "_e0_round"}, rk_round, 0);
    check({tag, "_e0_data"}, rk_data, exp_rk[0]);
    check({tag, "_e0_busy"}, busy, 1);
    check({tag, "_e0_kv"}, keys_valid, 0);
    check({tag, "_e0_done"}, done, 0);
    for (int r = 1; r <= 10; r++) begin
      start = dup && (r == 3 || r == 7);
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("%s_rk%0d_data", tag, r), rk_data, exp_rk[r]);
      check($sformatf("%s_rk%0d_round", tag, r), rk_round, 128'(r));
      check($sformatf("%s_rk%0d_valid", tag, r), rk_valid, 1);
      check($sformatf("%s_rk%0d_done", tag, r), done, 128'(r == 10));
      check($sformatf("%s_rk%0d_busy", tag, r), busy, 128'(r != 10));
      check($sformatf("%s_rk%0d_kv", tag, r), keys_valid, 128'(r == 10));
    end
    read_store(tag, 1'b0);
  endtask
  task automatic idle_check(string tag);
    @(posedge clk); #1;
    check({tag, "_idle_done"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_valid"}, rk_valid, 0);
    check({tag, "_idle_kv"}, keys_valid, 1);
    rk_idx = 4'd10;
    #1;
    check({tag, "_idle_rk10"}, round_key, exp_rk[10]);
  endtask
  initial begin
    init_sbox();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_kv", keys_valid, 0);
    check("rst_valid", rk_valid, 0);
    check("rst_data", rk_data, 0);
    check("rst_round", rk_round, 0);
    read_store("rst", 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_key("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    rk_idx = 4'd1; #1;
    check("fips_rk1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
    rk_idx = 4'd10; #1;
    check("fips_rk10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    idle_check("fips");
    run_key("zero", '0, 1'b0);
    rk_idx = 4'd1; #1;
    check("zero_rk1", round_key, 128'h62636363626363636263636362636363);
    rk_idx = 4'd10; #1;
    check("zero_rk10", round_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    idle_check("zero");
    run_key("dup", {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    idle_check("dup");
    for (int n = 0; n < 4; n++) run_key($sformatf("b2b%0d", n), {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    idle_check("b2b");
    key_in = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_kv", keys_valid, 0);
    check("mid_rst_valid", rk_valid, 0);
    read_store("mid_rst", 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_key("recover", {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    idle_check("recover");
`ifdef AES_KEY_ZEROIZE_EN
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    check("zz_kv", keys_valid, 0);
    check("zz_busy", busy, 0);
    read_store("zz", 1'b1);
    zeroize = 1'b1;
    start = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    zeroize = 1'b0;
    start = 1'b0;
    check("zzs_busy", busy, 0);
    check("zzs_valid", rk_valid, 0);
    @(posedge clk); #1;
    check("zzs_busy2", busy, 0);
    check("zzs_done", done, 0);
    check("zzs_kv", keys_valid, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
